// File: rtl/cpu_ram_ctrl.sv
// cpu_ram_ctrl
// ------------
// Word-addressed RAM controller shared by a 6502-style CPU port and a
// loader port. On leaving reset the whole array is cleared one word per
// cycle; only after that are the CPU and loader serviced. The loader
// always wins a cycle against the CPU (the CPU sees rdy=0 and holds its
// request). The decoded window [BASE, BASE+WINDOW) mirrors the DEPTH-word
// array every DEPTH addresses.
//
// Optional feature: define MEM_PARITY_EN to keep an even-parity bit per
// word and flag mismatches on reads (par_err). The loader can deliberately
// store a wrong parity bit through inj_err.
//
// Ports
//    clk       in   clock
//    rst_n     in   asynchronous active-low reset
//    addr      in   CPU address
//    wdata     in   CPU write data
//    wen       in   CPU write strobe (0 = read)
//    rdy       out  CPU access accepted this cycle
//    rdata     out  registered read data
//    rvalid    out  one-cycle pulse, rdata valid
//    hit       out  addr inside the decoded window (combinational)
//    ld_valid  in   loader write request
//    ld_addr   in   loader word index
//    ld_data   in   loader write data
//    ld_ready  out  loader write accepted
//    busy      out  clear sequence in progress
//    inj_err   in   store inverted parity on a loader write
//    par_err   out  parity mismatch, pulses with rvalid
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | write 0 to word r_cnt each cycle; CPU and loader stalled
// S_RUN   | normal service, loader has priority over the CPU

module cpu_ram_ctrl #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEPTH   = 2048,
   parameter int unsigned BASE    = 32'h0000_0000,
   parameter int unsigned WINDOW  = 32'h0000_2000,
   localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wen,
   output logic              rdy,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              hit,
   input  logic              ld_valid,
   input  logic [IDX_W-1:0]  ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              busy,
   input  logic              inj_err,
   output logic              par_err
);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;

   logic              w_busy;
   logic              w_rdy;
   logic              w_ld_ready;
   logic [32:0]       w_off;
   logic              w_hit;
   logic [IDX_W-1:0]  w_idx;
   logic              w_cpu_rd;
   logic              w_cpu_wr;
   logic              w_we;
   logic [IDX_W-1:0]  w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_unused;

   // 33-bit subtraction: bit 32 set means addr is below BASE.
   assign w_off = {1'b0, 32'(addr)} - {1'b0, BASE};
   assign w_hit = !w_off[32] && (w_off[31:0] < WINDOW);
   assign w_idx = w_off[IDX_W-1:0];

   assign w_cpu_rd = w_hit && w_rdy && !wen;
   assign w_cpu_wr = w_hit && w_rdy && wen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Wraps to 0 on the last clear word, so RUN starts with r_cnt=0.
         r_cnt   <= (r_state == S_CLEAR) ? r_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_rdy       = 1'b0;
      w_ld_ready  = 1'b0;
      case (r_state)
         S_CLEAR: begin
            w_busy = 1'b1;
            if (r_cnt == IDX_W'(DEPTH - 1)) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_ld_ready = 1'b1;
            w_rdy      = !ld_valid;
         end
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   // Single write port: clear, loader and CPU are mutually exclusive.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      if (r_state == S_CLEAR) begin
         w_we    = 1'b1;
         w_waddr = r_cnt;
      end else if (ld_valid) begin
         w_we    = 1'b1;
         w_waddr = ld_addr;
         w_wdata = ld_data;
      end else if (w_cpu_wr) begin
         w_we    = 1'b1;
         w_waddr = w_idx;
         w_wdata = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_cpu_rd;
         if (w_cpu_rd) r_rdata <= r_mem[w_idx];
      end
   end

`ifdef MEM_PARITY_EN
   logic r_par [DEPTH];
   logic r_par_err;
   logic w_wpar;

   // Stored bit makes data+bit even; the loader may flip it on purpose.
   assign w_wpar = (^w_wdata) ^ (ld_valid && w_ld_ready && inj_err);

   always_ff @(posedge clk) begin
      if (w_we) r_par[w_waddr] <= w_wpar;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_par_err <= 1'b0;
      else        r_par_err <= w_cpu_rd && (r_par[w_idx] != ^r_mem[w_idx]);
   end

   assign par_err = r_par_err;
`else
   assign par_err = 1'b0;
`endif

   assign w_unused = ^{w_off, inj_err};

   assign busy     = w_busy;
   assign rdy      = w_rdy;
   assign ld_ready = w_ld_ready;
   assign hit      = w_hit;
   assign rdata    = r_rdata;
   assign rvalid   = r_rvalid;

endmodule

// File: tb/tb_cpu_ram_ctrl.sv
// Self-checking bench for cpu_ram_ctrl: directed scenarios followed by
// random CPU / loader traffic, compared against an array model of the RAM.

module tb_cpu_ram_ctrl;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 2048;
   localparam int unsigned IDX_W  = 11;
   localparam int unsigned BASE   = 0;
   localparam int unsigned WINDOW = 'h2000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic              wen = 1'b0;
   logic              rdy;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              hit;
   logic              ld_valid = 1'b0;
   logic [IDX_W-1:0]  ld_addr = '0;
   logic [DATA_W-1:0] ld_data = '0;
   logic              ld_ready;
   logic              busy;
   logic              inj_err = 1'b0;
   logic              par_err;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] m_mem [DEPTH];
   bit         m_pbad [DEPTH];
   logic [7:0] m_rdata;

   cpu_ram_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .BASE   (BASE),
      .WINDOW (WINDOW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .wdata    (wdata),
      .wen      (wen),
      .rdy      (rdy),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .hit      (hit),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .busy     (busy),
      .inj_err  (inj_err),
      .par_err  (par_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion (errors=%0d of %0d checks)", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_hit(input int unsigned a);
      return (a >= BASE) && (a < BASE + WINDOW);
   endfunction

   function automatic int unsigned m_idx(input int unsigned a);
      return (a - BASE) % DEPTH;
   endfunction

   function automatic bit exp_perr(input bit bad);
`ifdef MEM_PARITY_EN
      return bad;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_clear();
      for (int i = 0; i < int'(DEPTH); i++) begin
         m_mem[i]  = 8'h00;
         m_pbad[i] = 1'b0;
      end
      m_rdata = 8'h00;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts rising edges until busy drops; must be exactly DEPTH.
   task automatic wait_clear(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 5000) begin
         step();
         n++;
      end
      chk(tag, n, DEPTH);
      model_clear();
   endtask

   task automatic cpu_op(input int unsigned a, input bit w, input logic [7:0] d);
      bit          h;
      int unsigned ix;
      bit          pe;
      h  = m_hit(a);
      ix = m_idx(a);
      addr     = ADDR_W'(a);
      wen      = w;
      wdata    = d;
      ld_valid = 1'b0;
      #1;
      chk("hit", 32'(hit), 32'(h));
      chk("rdy", 32'(rdy), 1);
      step();
      pe = 1'b0;
      if (h && !w) begin
         m_rdata = m_mem[ix];
         pe      = exp_perr(m_pbad[ix]);
      end
      if (h && w) begin
         m_mem[ix]  = d;
         m_pbad[ix] = 1'b0;
      end
      chk("rvalid", 32'(rvalid), 32'(h && !w));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("par_err", 32'(par_err), 32'(pe));
      wen = 1'b0;
   endtask

   task automatic ld_op(input int unsigned ix, input logic [7:0] d, input bit inj,
                        input int unsigned cpu_a, input bit cpu_w);
      ld_valid = 1'b1;
      ld_addr  = IDX_W'(ix);
      ld_data  = d;
      inj_err  = inj;
      addr     = ADDR_W'(cpu_a);
      wen      = cpu_w;
      wdata    = ~d;
      #1;
      chk("ld_rdy_block", 32'(rdy), 0);
      chk("ld_ready", 32'(ld_ready), 1);
      step();
      m_mem[ix]  = d;
      m_pbad[ix] = inj;
      chk("ld_rvalid", 32'(rvalid), 0);
      chk("ld_rdata", 32'(rdata), 32'(m_rdata));
      chk("ld_par_err", 32'(par_err), 0);
      ld_valid = 1'b0;
      inj_err  = 1'b0;
      wen      = 1'b0;
   endtask

   initial begin
      int unsigned a;
      int unsigned r;
      model_clear();

      // Reset values, asynchronously before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 1);
      chk("rst_rdy", 32'(rdy), 0);
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_par_err", 32'(par_err), 0);
      #9 rst_n = 1'b1;

      wait_clear("clear_len");
      chk("run_busy", 32'(busy), 0);

      cpu_op('h0123, 1'b0, 8'h00);
      cpu_op('h0010, 1'b1, 8'hA5);
      cpu_op('h0810, 1'b0, 8'h00);
      cpu_op('h1810, 1'b0, 8'h00);

      // Loader and CPU collide: loader wins, CPU retries next cycle.
      addr     = 16'h07FF;
      wen      = 1'b0;
      ld_valid = 1'b1;
      ld_addr  = 11'h7FF;
      ld_data  = 8'h3C;
      #1;
      chk("coll_rdy0", 32'(rdy), 0);
      step();
      m_mem[11'h7FF]  = 8'h3C;
      m_pbad[11'h7FF] = 1'b0;
      chk("coll_rvalid0", 32'(rvalid), 0);
      ld_valid = 1'b0;
      #1;
      chk("coll_rdy1", 32'(rdy), 1);
      step();
      m_rdata = 8'h3C;
      chk("coll_rvalid1", 32'(rvalid), 1);
      chk("coll_rdata", 32'(rdata), 32'h3C);

      cpu_op('h2000, 1'b0, 8'h00);
      cpu_op('h0800, 1'b1, 8'h5A);
      cpu_op('h0000, 1'b0, 8'h00);
      cpu_op('h1FFF, 1'b0, 8'h00);

      ld_op(5, 8'h01, 1'b1, 'h0005, 1'b0);
      cpu_op('h0005, 1'b0, 8'h00);
      cpu_op('h0005, 1'b1, 8'h02);
      cpu_op('h0805, 1'b0, 8'h00);

      // Random traffic with heavy index reuse near both ends of the array.
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(DEPTH - 16, DEPTH - 1);
         a = a + DEPTH * $urandom_range(0, 5);
         if (r <= 3)
            cpu_op(a, 1'b0, 8'h00);
         else if (r <= 5)
            cpu_op(a, 1'b1, 8'($urandom));
         else if (r <= 8)
            ld_op(m_idx(a), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 'h1FFF), 1'($urandom_range(0, 1)));
         else
            cpu_op($urandom_range('h2000, 'hFFFF), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      // Reset mid-RUN, then a reset pulse in the middle of the clear.
      cpu_op('h0010, 1'b0, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      chk("rrun_busy", 32'(busy), 1);
      chk("rrun_rdy", 32'(rdy), 0);
      chk("rrun_ld_ready", 32'(ld_ready), 0);
      chk("rrun_rdata", 32'(rdata), 0);
      chk("rrun_rvalid", 32'(rvalid), 0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 1000; i++) step();
      chk("mid_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      chk("mid_busy_after", 32'(busy), 1);
      chk("mid_rdy", 32'(rdy), 0);
      wait_clear("reclear_len");

      cpu_op('h0010, 1'b0, 8'h00);
      cpu_op('h07FF, 1'b0, 8'h00);
      cpu_op('h0005, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
